// File: rtl/avg_state_sequencer_if.sv
// avg_state_sequencer_if: groups the CPU strobes, state PROM, vector RAM and draw handshake.
// Latency: none, wiring only.
// Backpressure: draw completion (vec_done) is the only handshake carried here.
interface avg_state_sequencer_if #(
  parameter int unsigned PC_W = 13
);
  logic            go;
  logic            vgrst;
  logic [7:0]      prom_addr;
  logic            prom_cs;
  logic [3:0]      prom_dout;
  logic [PC_W-1:0] vram_addr;
  logic            vram_rd;
  logic [7:0]      vram_data;
  logic [31:0]     vec_word;
  logic [3:0]      op;
  logic            draw_go;
  logic            vec_done;
  logic            busy;
  logic            halted;
  logic            err;

  // Sequencer side.
  modport master (
    input  go, vgrst, prom_dout, vram_data, vec_done,
    output prom_addr, prom_cs, vram_addr, vram_rd, vec_word, op,
           draw_go, busy, halted, err
  );

  // Environment side: CPU, PROM, RAM and vector timer.
  modport slave (
    output go, vgrst, prom_dout, vram_data, vec_done,
    input  prom_addr, prom_cs, vram_addr, vram_rd, vec_word, op,
           draw_go, busy, halted, err
  );
endinterface

// File: rtl/avg_state_sequencer.sv
// avg_state_sequencer: walks the vector-generator state PROM and executes each decoded state.
// Latency: lookup-to-lookup is 3 cycles (no-op/jump), 4 cycles (RAM byte fetch), 2+N for a draw.
// Backpressure: DRAW waits on vec_done; a watchdog forces a halt with err set after DRAW_TO cycles.
module avg_state_sequencer #(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned DRAW_TO = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avg_state_sequencer_if.master bus
);

  // Watchdog counts 0..DRAW_TO-1; the last value seen without vec_done ends the draw.
  localparam int unsigned     WD_W    = (DRAW_TO > 1) ? $clog2(DRAW_TO) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAW_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_EXEC,
    S_MEM,
    S_DRAW
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [3:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0][7:0] data_q, data_d;
  logic [1:0]      k_q, k_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic            prom_cs;
  logic            vram_rd;
  logic            draw_go;
  logic [12:0]     jump_tgt;

  // Jump target is the 13-bit byte address held in data1[4:0]:data0.
  assign jump_tgt = {data_q[1][4:0], data_q[0]};

  // Register all sequencer state; async reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      op_q    <= '0;
      pc_q    <= '0;
      data_q  <= '0;
      k_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe decode; strobes depend only on the registered FSM state.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    data_d  = data_q;
    k_d     = k_q;
    wd_d    = wd_q;
    err_d   = err_q;
    prom_cs = 1'b0;
    vram_rd = 1'b0;
    draw_go = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        if (bus.go) begin
          pc_d    = '0;
          state_d = '0;
          op_d    = '0;
          fsm_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        prom_cs = 1'b1;
        fsm_d   = S_LATCH;
      end

      S_LATCH: begin
        state_d = bus.prom_dout;
        fsm_d   = S_EXEC;
      end

      S_EXEC: begin
        if (!state_q[3]) begin
          fsm_d = S_ADDR;
        end else if (!state_q[2]) begin
          // 10kk: fetch one instruction byte into slot k.
          vram_rd = 1'b1;
          pc_d    = pc_q + 1'b1;
          k_d     = state_q[1:0];
          fsm_d   = S_MEM;
        end else begin
          unique case (state_q[1:0])
            2'b00: begin
              draw_go = 1'b1;
              wd_d    = '0;
              fsm_d   = S_DRAW;
            end
            2'b01: begin
              pc_d  = PC_W'(jump_tgt);
              fsm_d = S_ADDR;
            end
            2'b10: begin
              fsm_d = S_IDLE;
            end
            default: begin
              // Reserved code behaves as a no-op.
              fsm_d = S_ADDR;
            end
          endcase
        end
      end

      S_MEM: begin
        data_d[k_q] = bus.vram_data;
        if (k_q == 2'd1) begin
          op_d = bus.vram_data[7:4];
        end
        fsm_d = S_ADDR;
      end

      S_DRAW: begin
        if (bus.vec_done) begin
          fsm_d = S_ADDR;
        end else if (wd_q == WD_LAST) begin
          err_d = 1'b1;
          fsm_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    // Soft reset overrides whatever the FSM decided this cycle, including err.
    if (bus.vgrst) begin
      fsm_d   = S_IDLE;
      state_d = '0;
      op_d    = '0;
      pc_d    = '0;
      data_d  = '0;
      k_d     = '0;
      wd_d    = '0;
      err_d   = 1'b0;
    end
  end

  assign bus.prom_addr = {op_q, state_q};
  assign bus.prom_cs   = prom_cs;
  assign bus.vram_addr = pc_q;
  assign bus.vram_rd   = vram_rd;
  assign bus.vec_word  = data_q;
  assign bus.op        = op_q;
  assign bus.draw_go   = draw_go;
  assign bus.halted    = (fsm_q == S_IDLE);
  assign bus.busy      = (fsm_q != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_avg_state_sequencer.sv
// tb_avg_state_sequencer: directed bench with an instruction-level reference model and literal checks.
// Latency: model predicts outputs every cycle; literal checks pin traces and boundary timing.
// Backpressure: vec_done driven directly by the stimulus to exercise stall, bypass and watchdog.
module tb_avg_state_sequencer;
  localparam int PC_W = 13;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  avg_state_sequencer_if #(.PC_W(PC_W)) bus ();

  avg_state_sequencer #(.PC_W(PC_W), .DRAW_TO(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // PROM and RAM models, both one-cycle registered reads.
  logic [3:0] prom [256];
  logic [7:0] ram  [1 << PC_W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.prom_dout <= '0;
      bus.vram_data <= '0;
    end else begin
      if (bus.prom_cs) bus.prom_dout <= prom[bus.prom_addr];
      if (bus.vram_rd) bus.vram_data <= ram[bus.vram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the instruction being executed and the cycle within it.
  // pos 0 = PROM lookup, 1 = nibble arrives, 2 = decoded action, 3 = RAM byte / draw wait.
  logic            m_idle;
  int              m_pos;
  logic [3:0]      m_st;
  logic [3:0]      m_op;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_fa;
  logic [7:0]      m_d [4];
  logic            m_err;
  int              m_wd;
  int              m_k;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || bus.vgrst) begin
      m_idle <= 1'b1;
      m_pos  <= 0;
      m_st   <= '0;
      m_op   <= '0;
      m_pc   <= '0;
      m_fa   <= '0;
      for (int i = 0; i < 4; i++) m_d[i] <= '0;
      m_err  <= 1'b0;
      m_wd   <= 0;
      m_k    <= 0;
    end else if (m_idle) begin
      if (bus.go) begin
        m_idle <= 1'b0;
        m_pos  <= 0;
        m_st   <= '0;
        m_op   <= '0;
        m_pc   <= '0;
      end
    end else begin
      case (m_pos)
        0: m_pos <= 1;
        1: begin
          m_st  <= prom[{m_op, m_st}];
          m_pos <= 2;
        end
        2: begin
          if (m_st == 4'hE) begin
            m_idle <= 1'b1;
          end else if (m_st == 4'hC) begin
            m_wd  <= 0;
            m_pos <= 3;
          end else if (m_st == 4'hD) begin
            m_pc  <= PC_W'((int'(m_d[1]) % 32) * 256 + int'(m_d[0]));
            m_pos <= 0;
          end else if (m_st >= 4'h8 && m_st <= 4'hB) begin
            m_k   <= int'(m_st) - 8;
            m_fa  <= m_pc;
            m_pc  <= PC_W'((int'(m_pc) + 1) % (1 << PC_W));
            m_pos <= 3;
          end else begin
            m_pos <= 0;
          end
        end
        default: begin
          if (m_st == 4'hC) begin
            if (bus.vec_done) m_pos <= 0;
            else if (m_wd == TO - 1) begin
              m_err  <= 1'b1;
              m_idle <= 1'b1;
            end else m_wd <= m_wd + 1;
          end else begin
            m_d[m_k] <= ram[m_fa];
            if (m_k == 1) m_op <= ram[m_fa][7:4];
            m_pos <= 0;
          end
        end
      endcase
    end
  end

  wire        e_cs   = !m_idle && (m_pos == 0);
  wire        e_rd   = !m_idle && (m_pos == 2) && (m_st[3:2] == 2'b10);
  wire        e_dg   = !m_idle && (m_pos == 2) && (m_st == 4'hC);
  wire [31:0] m_word = {m_d[3], m_d[2], m_d[1], m_d[0]};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("prom_cs", 32'(bus.prom_cs), 32'(e_cs));
      if (e_cs) chk("prom_addr", 32'(bus.prom_addr), 32'({m_op, m_st}));
      chk("vram_rd", 32'(bus.vram_rd), 32'(e_rd));
      if (e_rd) chk("vram_addr", 32'(bus.vram_addr), 32'(m_pc));
      chk("draw_go", 32'(bus.draw_go), 32'(e_dg));
      chk("halted", 32'(bus.halted), 32'(m_idle));
      chk("busy", 32'(bus.busy), 32'(!m_idle));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("vec_word", bus.vec_word, m_word);
      chk("op", 32'(bus.op), 32'(m_op));
      chk("cs_rd_excl", 32'(bus.prom_cs & bus.vram_rd), 32'd0);
    end
  end

  // Trace recorder for the literal address-sequence checks.
  logic [15:0] pa_q [$];
  logic [15:0] va_q [$];
  int          dg_n;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.prom_cs) pa_q.push_back(16'(bus.prom_addr));
      if (bus.vram_rd) va_q.push_back(16'(bus.vram_addr));
      if (bus.draw_go) dg_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic wait_dg(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.draw_go && n < 200);
    chk(nm, 32'(bus.draw_go), 32'd1);
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.halted && n < 300);
    chk(nm, 32'(bus.halted), 32'd1);
  endtask

  logic [15:0] exp_pa [12];
  logic [15:0] exp_va [6];

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int n;
    bus.go       = 1'b0;
    bus.vgrst    = 1'b0;
    bus.vec_done = 1'b0;
    dg_n         = 0;
    for (int i = 0; i < 256; i++) prom[i] = 4'hE;
    for (int i = 0; i < (1 << PC_W); i++) ram[i] = 8'h00;
    exp_pa = '{16'h00, 16'h08, 16'hA9, 16'hAC, 16'hA8, 16'h19,
               16'h1D, 16'h18, 16'h1A, 16'h1C, 16'h10, 16'h1F};
    exp_va = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h1FFF, 16'h0000};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("por_halted", 32'(bus.halted), 32'd1);
    chk("por_busy", 32'(bus.busy), 32'd0);
    chk("por_err", 32'(bus.err), 32'd0);
    chk("por_prom_cs", 32'(bus.prom_cs), 32'd0);
    #20 reset_n = 1'b1;
    tick();

    // Fetch, draw, jump with pc wrap, second draw with vec_done already high, halt.
    prom[8'h00] = 4'h8; prom[8'h08] = 4'h9; prom[8'hA9] = 4'hC;
    prom[8'hAC] = 4'h8; prom[8'hA8] = 4'h9; prom[8'h19] = 4'hD;
    prom[8'h1D] = 4'h8; prom[8'h18] = 4'hA; prom[8'h1A] = 4'hC;
    prom[8'h1C] = 4'h0; prom[8'h10] = 4'hF; prom[8'h1F] = 4'hE;
    ram[0] = 8'h34; ram[1] = 8'hA2; ram[2] = 8'hFF; ram[3] = 8'h1F;
    ram[13'h1FFF] = 8'h55;
    pa_q.delete(); va_q.delete(); dg_n = 0;
    pulse_go();
    @(negedge clk);
    chk("go_prom_cs", 32'(bus.prom_cs), 32'd1);
    chk("go_prom_addr", 32'(bus.prom_addr), 32'h00);
    wait_dg("draw1_seen");
    chk("fetch_data01", bus.vec_word & 32'hFFFF, 32'hA234);
    chk("fetch_op", 32'(bus.op), 32'hA);
    @(posedge clk); #1;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    repeat (9) tick();
    chk("draw_hold_busy", 32'(bus.busy), 32'd1);
    chk("draw_hold_cs", 32'(bus.prom_cs), 32'd0);
    bus.vec_done = 1'b1;
    tick();
    @(negedge clk);
    chk("draw_done_cs", 32'(bus.prom_cs), 32'd1);
    chk("draw_done_addr", 32'(bus.prom_addr), 32'hAC);
    wait_halt("run_a_halt");
    chk("pa_count", 32'(pa_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < pa_q.size(); i++) chk("pa_seq", 32'(pa_q[i]), 32'(exp_pa[i]));
    chk("va_count", 32'(va_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < va_q.size(); i++) chk("va_seq", 32'(va_q[i]), 32'(exp_va[i]));
    chk("draw_go_count", 32'(dg_n), 32'd2);
    chk("final_word", bus.vec_word, 32'h00341F55);
    chk("final_op", 32'(bus.op), 32'h1);

    // Async reset in the middle of a draw.
    bus.vec_done = 1'b0;
    prom[8'h00] = 4'hC;
    tick();
    pulse_go();
    wait_dg("draw_rst_seen");
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_halted", 32'(bus.halted), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_draw_go", 32'(bus.draw_go), 32'd0);
    chk("rst_prom_cs", 32'(bus.prom_cs), 32'd0);
    chk("rst_vec_word", bus.vec_word, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    tick();

    // Async reset while a RAM byte is in flight must not let it land.
    prom[8'h00] = 4'h8;
    pulse_go();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.vram_rd && n < 20);
    chk("fetch_rd_seen", 32'(bus.vram_rd), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_fetch_word", bus.vec_word, 32'd0);
    chk("rst_fetch_halted", 32'(bus.halted), 32'd1);

    // Watchdog: no vec_done for the whole draw window.
    prom[8'h00] = 4'hC;
    pulse_go();
    wait_dg("wd_draw_seen");
    n = 0;
    do begin @(negedge clk); if (bus.busy) n++; end while (bus.busy && n < 100);
    chk("wd_cycles", 32'(n), 32'(TO));
    chk("wd_err", 32'(bus.err), 32'd1);
    chk("wd_halted", 32'(bus.halted), 32'd1);
    @(posedge clk); #1;
    pulse_go();
    @(negedge clk);
    chk("err_sticky", 32'(bus.err), 32'd1);
    chk("err_sticky_busy", 32'(bus.busy), 32'd1);
    wait_halt("wd2_halt");
    @(posedge clk); #1;
    bus.vgrst = 1'b1;
    bus.go    = 1'b1;
    tick();
    bus.vgrst = 1'b0;
    bus.go    = 1'b0;
    @(negedge clk);
    chk("vgrst_go_halted", 32'(bus.halted), 32'd1);
    chk("vgrst_err_clr", 32'(bus.err), 32'd0);
    repeat (3) tick();
    chk("vgrst_go_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
